// File: rtl/cache_fill_ctrl_if.sv
// Bus bundle for cache_fill_ctrl: refill/store requests, memory read port
// and the data-store write port. slave = controller side, master = environment.
interface cache_fill_ctrl_if #(
  parameter int LINE_BITS = 128,
  parameter int BEAT_BITS = 32
);
  logic                 miss_valid;
  logic [31:0]          miss_addr;
  logic                 miss_ready;
  logic                 st_valid;
  logic [1:0]           st_index;
  logic [3:0]           st_way;
  logic [LINE_BITS-1:0] st_data;
  logic [LINE_BITS-1:0] st_mask;
  logic                 st_ready;
  logic                 mem_req_valid;
  logic [31:0]          mem_req_addr;
  logic                 mem_req_ready;
  logic                 mem_rsp_valid;
  logic [BEAT_BITS-1:0] mem_rsp_data;
  logic                 ds_valid;
  logic                 ds_w;
  logic [1:0]           ds_index;
  logic [3:0]           ds_way;
  logic [LINE_BITS-1:0] ds_data;
  logic [LINE_BITS-1:0] ds_mask;
  logic                 fill_done;
  logic [3:0]           fill_way;

  modport slave (
    input  miss_valid, miss_addr,
    input  st_valid, st_index, st_way,
    input  st_data, st_mask,
    input  mem_req_ready, mem_rsp_valid,
    input  mem_rsp_data,
    output miss_ready, st_ready,
    output mem_req_valid, mem_req_addr,
    output ds_valid, ds_w, ds_index,
    output ds_way, ds_data, ds_mask,
    output fill_done, fill_way
  );

  modport master (
    output miss_valid, miss_addr,
    output st_valid, st_index, st_way,
    output st_data, st_mask,
    output mem_req_ready, mem_rsp_valid,
    output mem_rsp_data,
    input  miss_ready, st_ready,
    input  mem_req_valid, mem_req_addr,
    input  ds_valid, ds_w, ds_index,
    input  ds_way, ds_data, ds_mask,
    input  fill_done, fill_way
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Write sequencer for a 4-way/4-set cache data store: 4-beat miss refills
// with per-set round-robin victims, and byte-masked store-hit merges.
// Ports: clk, rst (sync, active high), bus (cache_fill_ctrl_if.slave).
module cache_fill_ctrl #(
  parameter int LINE_BITS = 128,
  parameter int BEAT_BITS = 32
) (
  input logic              clk,
  input logic              rst,
  cache_fill_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    BEAT,
    FWR,
    SWR
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [1:0]           beat;
  logic [1:0]           idx;
  logic [31:0]          line_addr;
  logic [LINE_BITS-1:0] line;
  logic [LINE_BITS-1:0] mask_q;
  logic [3:0]           way_q;
  logic [1:0]           vptr [4];
  logic [3:0]           vway;

  assign vway = 4'b0001 << vptr[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= 2'd0;
      idx       <= 2'd0;
      line_addr <= 32'd0;
      line      <= '0;
      mask_q    <= '0;
      way_q     <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        vptr[i] <= 2'd0;
      end
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (bus.st_valid) begin
            idx    <= bus.st_index;
            way_q  <= bus.st_way;
            line   <= bus.st_data;
            mask_q <= bus.st_mask;
          end else if (bus.miss_valid) begin
            idx       <= bus.miss_addr[5:4];
            line_addr <= {bus.miss_addr[31:4], 4'b0};
            beat      <= 2'd0;
          end
        end
        BEAT: begin
          // Shift in from the top: after four beats, beat k sits
          // in bits [32k+31:32k].
          if (bus.mem_rsp_valid) begin
            line <= {bus.mem_rsp_data,
                     line[LINE_BITS-1:BEAT_BITS]};
            beat <= beat + 2'd1;
          end
        end
        FWR: vptr[idx] <= vptr[idx] + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx          = state;
    bus.miss_ready    = 1'b0;
    bus.st_ready      = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = 32'd0;
    bus.ds_valid      = 1'b0;
    bus.ds_w          = 1'b0;
    bus.ds_index      = 2'd0;
    bus.ds_way        = 4'd0;
    bus.ds_data       = '0;
    bus.ds_mask       = '0;
    bus.fill_done     = 1'b0;
    bus.fill_way      = 4'd0;
    unique case (state)
      IDLE: begin
        bus.st_ready   = 1'b1;
        bus.miss_ready = ~bus.st_valid;
        if (bus.st_valid) state_nx = SWR;
        else if (bus.miss_valid) state_nx = REQ;
      end
      REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = line_addr;
        if (bus.mem_req_ready) state_nx = BEAT;
      end
      BEAT: begin
        if (bus.mem_rsp_valid && beat == 2'd3)
          state_nx = FWR;
      end
      FWR: begin
        bus.ds_valid  = 1'b1;
        bus.ds_w      = 1'b1;
        bus.ds_index  = idx;
        bus.ds_way    = vway;
        bus.ds_data   = line;
        bus.ds_mask   = '1;
        bus.fill_done = 1'b1;
        bus.fill_way  = vway;
        state_nx      = IDLE;
      end
      SWR: begin
        bus.ds_valid = 1'b1;
        bus.ds_w     = 1'b1;
        bus.ds_index = idx;
        bus.ds_way   = way_q;
        bus.ds_data  = line;
        bus.ds_mask  = mask_q;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed testbench for cache_fill_ctrl: reset, refill, round-robin,
// store priority, back-to-back stores, backpressure, reset mid-refill.
module tb_cache_fill_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cache_fill_ctrl_if bus ();

  cache_fill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.miss_valid    = 1'b0;
    bus.miss_addr     = 32'd0;
    bus.st_valid      = 1'b0;
    bus.st_index      = 2'd0;
    bus.st_way        = 4'd0;
    bus.st_data       = '0;
    bus.st_mask       = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'd0;
  endtask

  // Drives one refill; reports what the DUT did in its write cycle.
  task automatic run_refill(
    input  logic [31:0]  a,
    input  logic [31:0]  b0, b1, b2, b3,
    input  int           stall,
    input  int           gap_at,
    output int           cyc,
    output logic [3:0]   way,
    output logic [127:0] data,
    output logic [127:0] mask,
    output logic [1:0]   idx,
    output logic         fd,
    output logic [3:0]   fw,
    output logic         addr_ok
  );
    logic [31:0] bt [4];
    int k;
    int n;
    logic gapped;
    bt[0] = b0; bt[1] = b1; bt[2] = b2; bt[3] = b3;
    addr_ok = 1'b1;
    gapped = 1'b0;
    bus.miss_valid = 1'b1;
    bus.miss_addr  = a;
    step();
    bus.miss_valid = 1'b0;
    cyc = 1;
    n = 0;
    while (n <= stall) begin
      bus.mem_req_ready = (n == stall);
      #1;
      if (bus.mem_req_valid !== 1'b1 ||
          bus.mem_req_addr !== {a[31:4], 4'b0})
        addr_ok = 1'b0;
      step();
      cyc++;
      n++;
    end
    bus.mem_req_ready = 1'b0;
    k = 0;
    while (k < 4) begin
      if (k == gap_at && !gapped) begin
        bus.mem_rsp_valid = 1'b0;
        gapped = 1'b1;
      end else begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = bt[k];
        k++;
      end
      step();
      cyc++;
    end
    bus.mem_rsp_valid = 1'b0;
    #1;
    n = 0;
    while (bus.ds_valid !== 1'b1 && n < 20) begin
      step();
      cyc++;
      n++;
    end
    way  = bus.ds_way;
    data = bus.ds_data;
    mask = bus.ds_mask;
    idx  = bus.ds_index;
    fd   = bus.fill_done;
    fw   = bus.fill_way;
    step();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.miss_ready !== 1'b1 || bus.st_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b%b exp 11",
               bus.miss_ready, bus.st_ready);
    end
    checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_mem got %b %h exp 0 0",
               bus.mem_req_valid, bus.mem_req_addr);
    end
    checks++;
    if (bus.ds_valid !== 1'b0 || bus.ds_w !== 1'b0 ||
        bus.ds_mask !== 128'd0 || bus.ds_data !== 128'd0) begin
      errors++;
      $display("FAIL reset_ds got v%b w%b m%h d%h exp zeros",
               bus.ds_valid, bus.ds_w, bus.ds_mask, bus.ds_data);
    end
    checks++;
    if (bus.ds_index !== 2'd0 || bus.ds_way !== 4'd0 ||
        bus.fill_done !== 1'b0 || bus.fill_way !== 4'd0) begin
      errors++;
      $display("FAIL reset_misc got %h %h %b %h exp zeros",
               bus.ds_index, bus.ds_way, bus.fill_done, bus.fill_way);
    end
  endtask

  task automatic test_single_refill;
    int c;
    logic [3:0] w, fw;
    logic [127:0] d, m;
    logic [1:0] ix;
    logic fd, aok;
    run_refill(32'h0000_1230, 32'h11111111, 32'h22222222,
               32'h33333333, 32'h44444444, 0, -1,
               c, w, d, m, ix, fd, fw, aok);
    checks++;
    if (aok !== 1'b1) begin
      errors++;
      $display("FAIL single_addr got bad exp 00001230");
    end
    checks++;
    if (c != 6) begin
      errors++;
      $display("FAIL single_latency got %0d exp 6", c);
    end
    checks++;
    if (d !== 128'h44444444_33333333_22222222_11111111) begin
      errors++;
      $display("FAIL single_data got %h", d);
    end
    checks++;
    if (m !== {128{1'b1}} || w !== 4'b0001 || ix !== 2'd3) begin
      errors++;
      $display("FAIL single_wr got m%h w%b i%0d exp ones 0001 3",
               m, w, ix);
    end
    checks++;
    if (fd !== 1'b1 || fw !== 4'b0001) begin
      errors++;
      $display("FAIL single_done got %b %b exp 1 0001", fd, fw);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_w [5];
    int c;
    logic [3:0] w, fw;
    logic [127:0] d, m;
    logic [1:0] ix;
    logic fd, aok;
    exp_w[0] = 4'b0001; exp_w[1] = 4'b0010; exp_w[2] = 4'b0100;
    exp_w[3] = 4'b1000; exp_w[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      run_refill(32'h0000_0010 | (i << 8), i, i + 1, i + 2, i + 3,
                 0, -1, c, w, d, m, ix, fd, fw, aok);
      checks++;
      if (w !== exp_w[i] || ix !== 2'd1 || fw !== exp_w[i]) begin
        errors++;
        $display("FAIL rr_way%0d got %b i%0d exp %b i1",
                 i, w, ix, exp_w[i]);
      end
    end
    run_refill(32'h0000_4000, 1, 2, 3, 4, 0, -1,
               c, w, d, m, ix, fd, fw, aok);
    checks++;
    if (w !== 4'b0001 || ix !== 2'd0) begin
      errors++;
      $display("FAIL rr_other_set got %b i%0d exp 0001 i0", w, ix);
    end
    run_refill(32'h0000_0230, 1, 2, 3, 4, 0, -1,
               c, w, d, m, ix, fd, fw, aok);
    checks++;
    if (w !== 4'b0010 || ix !== 2'd3) begin
      errors++;
      $display("FAIL rr_set3 got %b i%0d exp 0010 i3", w, ix);
    end
  endtask

  task automatic test_store_priority;
    int n;
    bus.st_valid   = 1'b1;
    bus.st_index   = 2'd2;
    bus.st_way     = 4'b0100;
    bus.st_data    = 128'hA5A5;
    bus.st_mask    = 128'hFF;
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 32'h0000_0520;
    #1;
    checks++;
    if (bus.miss_ready !== 1'b0 || bus.st_ready !== 1'b1) begin
      errors++;
      $display("FAIL prio_ready got m%b s%b exp m0 s1",
               bus.miss_ready, bus.st_ready);
    end
    step();
    bus.st_valid = 1'b0;
    #1;
    checks++;
    if (bus.ds_valid !== 1'b1 || bus.ds_w !== 1'b1 ||
        bus.ds_way !== 4'b0100 || bus.ds_index !== 2'd2 ||
        bus.ds_mask !== 128'hFF || bus.ds_data !== 128'hA5A5 ||
        bus.fill_done !== 1'b0) begin
      errors++;
      $display("FAIL prio_swr got v%b w%b i%0d m%h d%h fd%b",
               bus.ds_valid, bus.ds_way, bus.ds_index,
               bus.ds_mask, bus.ds_data, bus.fill_done);
    end
    checks++;
    if (bus.miss_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_busy got %b exp 0", bus.miss_ready);
    end
    step();
    #1;
    checks++;
    if (bus.miss_ready !== 1'b1) begin
      errors++;
      $display("FAIL prio_miss_acc got %b exp 1", bus.miss_ready);
    end
    step();
    bus.miss_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    checks++;
    if (bus.mem_req_valid !== 1'b1 ||
        bus.mem_req_addr !== 32'h0000_0520) begin
      errors++;
      $display("FAIL prio_req got %b %h exp 1 00000520",
               bus.mem_req_valid, bus.mem_req_addr);
    end
    step();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rsp_data = 32'hC0 + i;
      step();
    end
    bus.mem_rsp_valid = 1'b0;
    #1;
    n = 0;
    while (bus.ds_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (bus.ds_way !== 4'b0001 || bus.ds_index !== 2'd2 ||
        bus.ds_data !== 128'h000000C3_000000C2_000000C1_000000C0) begin
      errors++;
      $display("FAIL prio_fill got w%b i%0d d%h",
               bus.ds_way, bus.ds_index, bus.ds_data);
    end
    step();
  endtask

  task automatic test_back_to_back;
    bus.st_valid = 1'b1;
    bus.st_index = 2'd1;
    bus.st_way   = 4'b1000;
    bus.st_data  = 128'h1111;
    bus.st_mask  = 128'hF0;
    step();
    bus.st_data  = 128'h2222;
    bus.st_mask  = 128'h0F;
    bus.st_way   = 4'b0010;
    #1;
    checks++;
    if (bus.st_ready !== 1'b0 || bus.ds_data !== 128'h1111 ||
        bus.ds_mask !== 128'hF0 || bus.ds_way !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_first got r%b d%h m%h w%b",
               bus.st_ready, bus.ds_data, bus.ds_mask, bus.ds_way);
    end
    step();
    #1;
    checks++;
    if (bus.st_ready !== 1'b1 || bus.ds_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got r%b v%b exp 1 0",
               bus.st_ready, bus.ds_valid);
    end
    step();
    bus.st_valid = 1'b0;
    #1;
    checks++;
    if (bus.ds_valid !== 1'b1 || bus.ds_data !== 128'h2222 ||
        bus.ds_mask !== 128'h0F || bus.ds_way !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_second got v%b d%h m%h w%b",
               bus.ds_valid, bus.ds_data, bus.ds_mask, bus.ds_way);
    end
    step();
  endtask

  task automatic test_backpressure;
    int c;
    logic [3:0] w, fw;
    logic [127:0] d, m;
    logic [1:0] ix;
    logic fd, aok;
    run_refill(32'h0000_8F00, 32'hAAAA0000, 32'hBBBB1111,
               32'hCCCC2222, 32'hDDDD3333, 3, 2,
               c, w, d, m, ix, fd, fw, aok);
    checks++;
    if (aok !== 1'b1) begin
      errors++;
      $display("FAIL bp_addr got unstable exp 00008F00");
    end
    checks++;
    if (c != 10) begin
      errors++;
      $display("FAIL bp_latency got %0d exp 10", c);
    end
    checks++;
    if (d !== 128'hDDDD3333_CCCC2222_BBBB1111_AAAA0000 ||
        w !== 4'b0010 || ix !== 2'd0) begin
      errors++;
      $display("FAIL bp_data got %h w%b i%0d", d, w, ix);
    end
  endtask

  task automatic test_reset_mid_refill;
    int c;
    logic [3:0] w, fw;
    logic [127:0] d, m;
    logic [1:0] ix;
    logic fd, aok;
    logic leak;
    leak = 1'b0;
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 32'h0000_1230;
    step();
    bus.miss_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0BAD0000;
    step();
    bus.mem_rsp_data  = 32'h0BAD0001;
    step();
    rst = 1'b1;
    bus.mem_rsp_data  = 32'h0BAD0002;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.mem_rsp_data = 32'hBEEF0000 + i;
      #1;
      if (bus.ds_valid !== 1'b0 || bus.mem_req_valid !== 1'b0)
        leak = 1'b1;
      step();
    end
    bus.mem_rsp_valid = 1'b0;
    checks++;
    if (leak !== 1'b0) begin
      errors++;
      $display("FAIL rst_stray got write exp none");
    end
    run_refill(32'h0000_1230, 32'h01010101, 32'h02020202,
               32'h03030303, 32'h04040404, 0, -1,
               c, w, d, m, ix, fd, fw, aok);
    checks++;
    if (w !== 4'b0001 || c != 6 ||
        d !== 128'h04040404_03030303_02020202_01010101) begin
      errors++;
      $display("FAIL rst_refill got w%b c%0d d%h", w, c, d);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_refill();
    test_round_robin();
    test_store_priority();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_refill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Sequencing block directly upstream of the 4-way, 4-set, 16-byte-line cache data store. It drives every write into the data store:
- **Miss refills:** fetches a line from memory as four 32-bit beats, assembles it, picks a victim way round-robin per set, and writes the full line.
- **Store-hit merges:** forwards byte-masked writes into a known way.

Its outputs connect one-for-one to the data store's valid/index/way/data_in/mask_in/w inputs.

## Interface
Parameters:
- LINE_BITS, default 128: cache line width. Must equal 4 × BEAT_BITS.
- BEAT_BITS, default 32: memory response beat width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- miss_valid  in  1  refill request.
- miss_addr  in  32  miss byte address; index = [5:4]; line address = {[31:4], 4'b0}.
- miss_ready  out  1  refill request accepted this cycle.
- st_valid  in  1  store-hit write request.
- st_index  in  2  set index of the store.
- st_way  in  4  one-hot hit way of the store.
- st_data  in  128  store data, line-aligned.
- st_mask  in  128  per-bit write mask; 1 = write.
- st_ready  out  1  store request accepted this cycle.
- mem_req_valid  out  1  line read request to memory.
- mem_req_addr  out  32  line-aligned request address.
- mem_req_ready  in  1  memory accepts the request.
- mem_rsp_valid  in  1  response beat valid.
- mem_rsp_data  in  32  response beat.
- ds_valid, ds_w  out  1 each  data store write strobe; both high only in write cycles.
- ds_index  out  2  data store set index.
- ds_way  out  4  data store one-hot way.
- ds_data  out  128  data store write data.
- ds_mask  out  128  data store write mask.
- fill_done  out  1  one-cycle pulse in the refill write cycle.
- fill_way  out  4  way written; valid while fill_done is high.

## Operation
States: IDLE, REQ, BEAT, FWR (fill write), SWR (store write).

- **IDLE**
  - st_ready = 1.
  - miss_ready = ~st_valid, so a store has priority over a miss in the same cycle.
  - st_valid=1: latch st_index, st_way, st_data and st_mask; next state SWR.
  - Else miss_valid=1: latch the index and line address; clear the beat counter; next state REQ.
- **REQ**
  - mem_req_valid = 1 and mem_req_addr = latched line address, held stable until mem_req_ready=1.
  - Next state BEAT on the cycle mem_req_ready=1.
- **BEAT**
  - Each cycle with mem_rsp_valid=1, write the beat into line bits [32k+31:32k], where k is the 2-bit beat counter, then increment k.
  - When the 4th beat (k=3) is captured, next state FWR.
- **FWR**
  - ds_valid = ds_w = 1, ds_index = latched index, ds_data = assembled line.
  - ds_mask = all ones.
  - ds_way = one-hot(victim_ptr[index]).
  - fill_done = 1, fill_way = ds_way.
  - victim_ptr[index] increments, wrapping 3→0.
  - Next state IDLE.
- **SWR**
  - ds_valid = ds_w = 1; ds_index, ds_way, ds_data and ds_mask = latched store fields.
  - Victim pointers unchanged.
  - Next state IDLE.
- Outside FWR and SWR, ds_valid = ds_w = 0, and ds_mask = 0 so no write can leak.
- mem_rsp_valid outside BEAT is ignored and discarded.
- st_valid and miss_valid outside IDLE are not accepted; the requester holds them.
- Victim pointers are four independent 2-bit counters, one per set.

## Timing
- **Reset** (any state, including mid-refill):
  - State returns to IDLE; the beat counter and all victim pointers clear to 0.
  - The partially assembled line is discarded.
  - Outputs reset to: miss_ready=1, st_ready=1, mem_req_valid=0, ds_valid=0, ds_w=0, ds_mask=0, fill_done=0, fill_way=0. Data and address outputs reset to 0.
  - A memory response that arrives after reset is ignored.
- **Miss timing:**
  - Miss accepted at cycle 0; mem_req_valid is high from cycle 1.
  - With mem_req_ready at cycle 1 and beats on cycles 2-5, FWR is cycle 6.
  - Minimum miss-to-write latency is therefore 6 cycles. Gaps in mem_rsp_valid stretch BEAT one cycle per gap.
- **Store timing:** store accepted at cycle 0 → SWR write at cycle 1; back-to-back stores allow one store every 2 cycles.
- **Throughput:** the earliest new acceptance is the cycle after FWR or SWR; there is no overlap.

## Test plan
- **Reset values:** assert rst 2 cycles → all outputs at their reset values; state IDLE.
- **Single refill:**
  - Stimulus: miss_addr=0x0000_1230 (index 3); beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles.
  - Required: mem_req_addr=0x0000_1230; FWR at cycle 6 with ds_data=0x44444444_33333333_22222222_11111111, ds_mask=all ones, ds_way=4'b0001, fill_done=1.
- **Round-robin victims:** five refills to index 1 → ds_way sequence 0001, 0010, 0100, 1000, 0001; victim pointers for the other sets stay 0.
- **Store priority:**
  - Stimulus: st_valid and miss_valid together in IDLE with st_way=4'b0100, st_index=2, st_mask=0xFF.
  - Required: miss_ready=0; the next cycle writes ds_way=0100, ds_index=2, ds_mask=0xFF; the miss is accepted in the following IDLE cycle.
- **Backpressure and gaps:** mem_req_ready low for 3 cycles and one idle cycle between beats 2 and 3 → mem_req_addr stays stable; FWR lands at cycle 10; beat order is correct.
- **Reset mid-refill:**
  - Stimulus: rst after 2 beats, then 2 stray mem_rsp_valid beats, then a new miss.
  - Required: no ds write from the stray beats; the new refill writes way 0001 with fresh data.
